uart_tx_buffered: RTL and testbench



---
 rtl/uart_defs_pkg.sv | 9 +
 rtl/sync_fifo.sv | 39 +++
 rtl/uart_tx_buffered.sv | 107 ++++++++++
 tb/tb_uart_tx_buffered.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// uart_defs_pkg: UART constants, FSM state encoding and baud divisor shared by TX and RX
package uart_defs_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic int baud_div(input int clock_rate, input int baud_rate);
    return (clock_rate + baud_rate / 2) / baud_rate;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; count tells full from empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rd_ptr];
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset; only entries below count are ever read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed through a small valid/ready FIFO
module uart_tx_buffered
  import uart_defs_pkg::*;
#(
  parameter int CLOCK_RATE = 20000000,
  parameter int BAUD_RATE = 9600,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] in,
  output logic                 ready,
  output logic                 out,
  output logic                 busy,
  output logic [CW-1:0]        count
);
  localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE);
  localparam int STOP_DIV = STOP_BITS * DIV;
  localparam int BW = $clog2(STOP_DIV);
  localparam int IW = $clog2(DATA_BITS);
  uart_state_t state, state_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n, head;
  logic out_n, full, empty, pop, tick;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(valid && ready),
    .pop(pop),
    .wdata(in),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign ready = !full && !reset;
  assign busy = state != IDLE || count != '0;
  assign tick = cnt == BW'(state == STOP ? STOP_DIV - 1 : DIV - 1);
  // frame sequencing: popping the head byte and driving the start bit happen on the same edge
  always_comb begin
    state_n = state;
    cnt_n = tick ? '0 : cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    out_n = out;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable && !empty) begin
          pop = 1'b1;
          sh_n = head;
          out_n = 1'b0;
          state_n = START;
        end
      end
      START:
        if (tick) begin
          idx_n = '0;
          out_n = sh[0];
          state_n = DATA;
        end
      DATA:
        if (tick) begin
          if (idx == IW'(DATA_BITS - 1)) begin
            out_n = 1'b1;
            state_n = STOP;
          end else begin
            idx_n = idx + 1'b1;
            sh_n = sh >> 1;
            out_n = sh[1];
          end
        end
      STOP:
        if (tick) begin
          if (enable && !empty) begin
            pop = 1'b1;
            sh_n = head;
            out_n = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      default: state_n = IDLE;
    endcase
  end
  // state, baud counter and shift register; reset abandons any partial frame
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      out <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      out <= out_n;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: frame-timeline reference model, line decoder, vector table and corner sequences
module tb_uart_tx_buffered;
  localparam int CR = 800, BR = 100, DEPTH = 4;
  localparam int DIV = (CR + BR / 2) / BR;
  localparam int FRAME = 10 * DIV;
  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } vec_t;
  logic clk = 1'b0;
  logic reset, enable, valid, ready, out, busy;
  logic [7:0] in;
  logic [2:0] count;
  logic rst_d, valid_d, ready_d, out_d, busy_d;
  logic [7:0] in_d;
  logic [2:0] count_d;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [9:0] exp_rx[$], got[$];
  bit m_active, m_acc;
  int m_t;
  logic [7:0] m_cur;
  vec_t tbl[5];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .valid(valid), .in(in),
    .ready(ready), .out(out), .busy(busy), .count(count)
  );
  uart_tx_buffered u_def (
    .clk(clk), .reset(rst_d), .enable(1'b1), .valid(valid_d), .in(in_d),
    .ready(ready_d), .out(out_d), .busy(busy_d), .count(count_d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_out();
    int k;
    k = m_t / DIV;
    if (!m_active) return 1'b1;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  // advance the reference model over one edge, then compare all outputs
  task automatic step();
    bit done, start;
    int n;
    n = q.size();
    m_acc = valid && n < DEPTH && !reset;
    if (reset) begin
      q.delete();
      m_active = 0;
      m_t = 0;
    end else begin
      done = m_active && m_t == FRAME - 1;
      if (done) exp_rx.push_back({1'b1, m_cur, 1'b0});
      start = (!m_active || done) && enable && n > 0;
      if (start) begin
        m_cur = q.pop_front();
        m_active = 1;
        m_t = 0;
      end else if (done) m_active = 0;
      else if (m_active) m_t++;
      if (m_acc) q.push_back(in);
    end
    @(posedge clk);
    #2;
    chk("out", out, m_out());
    chk("ready", ready, q.size() < DEPTH && !reset);
    chk("busy", busy, m_active || q.size() > 0);
    chk("count", count, q.size());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string name);
    chk({name, "_frames"}, got.size(), exp_rx.size());
    while (got.size() > 0 && exp_rx.size() > 0) chk({name, "_frame"}, got.pop_front(), exp_rx.pop_front());
    got.delete();
    exp_rx.delete();
  endtask

  // independent line decoder: samples each bit mid-period after a falling start edge
  initial begin
    bit on;
    int c;
    logic [9:0] f;
    on = 0;
    c = 0;
    f = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) on = 0;
      else if (!on && out === 1'b0) begin
        on = 1;
        c = 0;
      end
      if (on) begin
        if (c % DIV == DIV / 2) f[c/DIV] = out;
        if (c == 9 * DIV + DIV / 2) begin
          got.push_back(f);
          on = 0;
        end
        c++;
      end
    end
  end

  initial begin
    logic [7:0] f6[6];
    int k, g, gap, acc5, bad, lo, tot;
    tbl[0] = '{8'h41, 10'h282};
    tbl[1] = '{8'h55, 10'h2AA};
    tbl[2] = '{8'hAA, 10'h354};
    tbl[3] = '{8'h00, 10'h200};
    tbl[4] = '{8'hFF, 10'h3FE};
    f6 = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    reset = 1; enable = 1; valid = 0; in = '0;
    rst_d = 1; valid_d = 0; in_d = '0;
    m_active = 0; m_t = 0; m_cur = '0; m_acc = 0;
    run(3);
    chk("rst_ready", ready, 0);
    chk("rst_out", out, 1);
    reset = 0;
    rst_d = 0;
    run(2);
    chk("idle_ready", ready, 1);

    // single frames against hand-written bit patterns
    for (int v = 0; v < 5; v++) begin
      valid = 1;
      in = tbl[v].data;
      step();
      valid = 0;
      for (int b = 0; b < 10; b++)
        for (int j = 0; j < DIV; j++) begin
          step();
          chk("table_bit", out, tbl[v].bits[b]);
        end
      chk("table_busy_end", busy, 1);
      step();
      chk("table_busy_drop", busy, 0);
      run(3);
    end
    drain("table");

    // back-to-back pushes with the line running
    in = 8'h55;
    foreach (tbl[v]) if (v >= 1 && v <= 4) begin
      chk("b2b_ready", ready, 1);
      valid = 1;
      in = tbl[v].data;
      step();
    end
    valid = 0;
    run(4 * FRAME + 10);
    drain("b2b");

    // preload four bytes with enable low, then release: no gap between frames
    enable = 0;
    for (int v = 1; v <= 4; v++) begin
      valid = 1;
      in = tbl[v].data;
      step();
    end
    valid = 0;
    chk("preload_count", count, 4);
    enable = 1;
    step();
    chk("preload_pop1", count, 3);
    for (int v = 2; v >= 0; v--) begin
      run(FRAME);
      chk("preload_pop", count, v);
    end
    run(FRAME + 10);
    drain("preload");

    // full FIFO with valid held over six bytes
    k = 0; g = 0; gap = 0; acc5 = 0;
    valid = 1;
    in = f6[0];
    while (k < 6 && g < 400) begin
      step();
      if (m_acc) begin
        k++;
        if (k == 5) begin
          chk("full_ready_low", ready, 0);
          acc5 = g;
        end
        if (k == 6) gap = g - acc5;
        if (k < 6) in = f6[k];
      end
      g++;
    end
    valid = 0;
    chk("full_accepts", k, 6);
    chk("full_gap", gap, FRAME - 2);
    run(6 * FRAME);
    drain("full");

    // enable gating
    enable = 0;
    valid = 1;
    in = 8'h31;
    step();
    valid = 0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (out !== 1'b1 || count !== 3'd1 || busy !== 1'b1) bad++;
    end
    chk("gate_hold", bad, 0);
    enable = 1;
    step();
    chk("gate_start", out, 0);
    run(20);
    enable = 0;
    valid = 1;
    in = 8'h32;
    step();
    valid = 0;
    run(FRAME + 200);
    chk("gate_stop_out", out, 1);
    chk("gate_stop_count", count, 1);
    enable = 1;
    run(FRAME + 20);
    drain("gate");

    // reset during data bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      valid = 1;
      in = 8'h11 * (i + 1);
      step();
    end
    valid = 0;
    chk("rmf_count", count, 2);
    run(33);
    reset = 1;
    step();
    chk("rmf_out", out, 1);
    chk("rmf_count0", count, 0);
    chk("rmf_ready", ready, 0);
    chk("rmf_busy", busy, 0);
    reset = 0;
    step();
    chk("rmf_ready1", ready, 1);
    run(200);
    chk("rmf_idle", out, 1);
    drain("rmf");

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      valid = $urandom_range(0, 1) == 1;
      in = 8'($urandom);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      step();
    end
    valid = 0;
    enable = 1;
    run(6 * FRAME);
    drain("rand");

    // default parameters: exact start-bit and frame length
    valid_d = 1;
    in_d = 8'h0D;
    @(posedge clk);
    #2;
    valid_d = 0;
    g = 0;
    while (out_d !== 1'b0 && g < 10) begin
      @(posedge clk);
      #2;
      g++;
    end
    chk("def_start_seen", out_d, 0);
    lo = 1;
    while (lo < 3000) begin
      @(posedge clk);
      #2;
      if (out_d !== 1'b0) break;
      lo++;
    end
    chk("def_start_len", lo, 2083);
    tot = lo;
    while (busy_d === 1'b1 && tot < 25000) begin
      tot++;
      @(posedge clk);
      #2;
    end
    chk("def_frame_len", tot, 20830);
    chk("def_idle_out", out_d, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
